// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM masters.
// One command issued per cycle; read data returns to the issuing master one cycle later.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              busy
);

    logic req_0, req_1;
    logic grant_0, grant_1;
    logic issue, grant_idx;
    logic last_grant;
    logic rd_pending_p1, rd_owner_p1;

    // Stage p0: arbitration and command issue (combinational)
    always_comb begin
        req_0   = m0_read | m0_write;
        req_1   = m1_read | m1_write;
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!reset) begin
            if (req_0 && req_1) begin
                // Both contending: the master that did not win last time goes now.
                grant_0 = last_grant;
                grant_1 = ~last_grant;
            end else begin
                grant_0 = req_0;
                grant_1 = req_1;
            end
        end
        issue     = grant_0 | grant_1;
        grant_idx = grant_1;
    end

    assign mem_chipselect = issue;
    assign mem_address    = grant_1 ? m1_address    : m0_address;
    assign mem_byteenable = grant_1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant_1 ? m1_writedata  : m0_writedata;
    assign mem_write      = grant_1 ? m1_write      : (grant_0 & m0_write);

    assign m0_waitrequest = reset | (req_0 & ~grant_0);
    assign m1_waitrequest = reset | (req_1 & ~grant_1);

    assign mem_clken     = 1'b1;
    assign mem_reset_req = reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= 1'b1;
            rd_pending_p1 <= 1'b0;
            rd_owner_p1   <= 1'b0;
        end else begin
            if (issue) begin
                last_grant <= grant_idx;
            end
            rd_pending_p1 <= issue & ~mem_write;
            rd_owner_p1   <= grant_idx;
        end
    end

    // Stage p1: read return, RAM data routed straight to both masters
    assign m0_readdatavalid = rd_pending_p1 & ~rd_owner_p1 & ~reset;
    assign m1_readdatavalid = rd_pending_p1 &  rd_owner_p1 & ~reset;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    assign busy = rd_pending_p1 | req_0 | req_1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a byte-enabled, 1-cycle-latency RAM model.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              m0_waitrequest, m1_waitrequest;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken, mem_reset_req;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] ram [4];

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata), .busy(busy)
    );

    // Single-port RAM: byte-lane writes, registered read data
    always @(posedge clk) begin
        if (mem_chipselect && mem_write) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
        if (mem_chipselect && !mem_write) mem_readdata <= ram[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    endtask

    initial begin
        reset = 1'b1;
        drv0(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        drv1(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        mem_readdata = '0;

        // Reset with both masters requesting
        next(); settle();
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_mwr", mem_write, 0);
        chk("rst_rstreq", mem_reset_req, 1);
        chk("rst_rdv0", m0_readdatavalid, 0);
        chk("rst_rdv1", m1_readdatavalid, 0);
        next();
        reset = 1'b0;
        drv0(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        settle();
        chk("idle_busy", busy, 0);
        chk("idle_cs", mem_chipselect, 0);
        chk("idle_clken", mem_clken, 1);
        chk("idle_rstreq", mem_reset_req, 0);
        chk("idle_rdv0", m0_readdatavalid, 0);

        // Single write then read on m0
        next(); drv0(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF); settle();
        chk("wr_wait0", m0_waitrequest, 0);
        chk("wr_cs", mem_chipselect, 1);
        chk("wr_mwr", mem_write, 1);
        chk("wr_addr", mem_address, 2);
        next(); drv0(1'b1, 1'b0, 2'd2, 32'h0, 4'hF); settle();
        chk("rd_wait0", m0_waitrequest, 0);
        chk("rd_mwr", mem_write, 0);
        chk("rd_cs", mem_chipselect, 1);
        next(); drv0(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("rd_rdv0", m0_readdatavalid, 1);
        chk("rd_data0", m0_readdata, 32'hDEADBEEF);
        chk("rd_rdv1", m1_readdatavalid, 0);
        chk("rd_busy", busy, 1);
        next(); settle();
        chk("rd_rdv0_off", m0_readdatavalid, 0);
        chk("rd_busy_off", busy, 0);

        // Concurrent writes, last grant was m0 so m1 goes first
        next();
        drv0(1'b0, 1'b1, 2'd1, 32'h01010101, 4'hF);
        drv1(1'b0, 1'b1, 2'd3, 32'h03030303, 4'hF);
        settle();
        chk("cw_wait0", m0_waitrequest, 1);
        chk("cw_wait1", m1_waitrequest, 0);
        chk("cw_addr", mem_address, 3);
        next(); drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("cw2_wait0", m0_waitrequest, 0);
        chk("cw2_addr", mem_address, 1);

        // Continuous contention on reads, last grant m0 so m1 leads
        next();
        drv0(1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
        drv1(1'b1, 1'b0, 2'd3, 32'h0, 4'hF);
        settle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                next(); settle();
            end
            chk("ct_wait0", m0_waitrequest, (i % 2 == 0));
            chk("ct_wait1", m1_waitrequest, (i % 2 == 1));
            chk("ct_addr", mem_address, (i % 2 == 0) ? 3 : 1);
            chk("ct_rdv1", m1_readdatavalid, (i % 2 == 1));
            chk("ct_rdv0", m0_readdatavalid, (i > 0 && i % 2 == 0));
            if (i % 2 == 1) chk("ct_data1", m1_readdata, 32'h03030303);
            else if (i > 0) chk("ct_data0", m0_readdata, 32'h01010101);
        end
        next();
        drv0(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        settle();
        chk("ct_end_rdv0", m0_readdatavalid, 1);
        chk("ct_end_data0", m0_readdata, 32'h01010101);

        // Byte enables on m1
        next(); drv1(1'b0, 1'b1, 2'd0, 32'h11223344, 4'hF); settle();
        chk("be_pre_wait1", m1_waitrequest, 0);
        next(); drv1(1'b0, 1'b1, 2'd0, 32'hAABBCCDD, 4'h5); settle();
        chk("be_mbe", mem_byteenable, 4'h5);
        next(); drv1(1'b1, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        next(); drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("be_rdv1", m1_readdatavalid, 1);
        chk("be_data1", m1_readdata, 32'h11BB33DD);

        // m0 write vs m1 read to the same word, last grant m1
        next();
        drv0(1'b0, 1'b1, 2'd0, 32'hCAFEF00D, 4'hF);
        drv1(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        settle();
        chk("wvr_wait0", m0_waitrequest, 0);
        chk("wvr_wait1", m1_waitrequest, 1);
        chk("wvr_mwr", mem_write, 1);
        next(); drv0(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("wvr2_wait1", m1_waitrequest, 0);
        chk("wvr2_mwr", mem_write, 0);
        next(); drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("wvr_rdv1", m1_readdatavalid, 1);
        chk("wvr_data1", m1_readdata, 32'hCAFEF00D);
        chk("wvr_rdv0", m0_readdatavalid, 0);

        // Read and write together on m1 behaves as a write
        next(); drv1(1'b1, 1'b1, 2'd2, 32'h5A5A5A5A, 4'hF); settle();
        chk("rw_mwr", mem_write, 1);
        chk("rw_wait1", m1_waitrequest, 0);
        next(); drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("rw_rdv1", m1_readdatavalid, 0);
        chk("rw_rdv0", m0_readdatavalid, 0);
        next(); drv0(1'b1, 1'b0, 2'd2, 32'h0, 4'hF); settle();
        next(); drv0(1'b0, 1'b0, 2'd0, 32'h0, 4'hF); settle();
        chk("rw_chk_rdv0", m0_readdatavalid, 1);
        chk("rw_chk_data0", m0_readdata, 32'h5A5A5A5A);

        // Reset right after an m0 read issue drops the return
        next(); drv0(1'b1, 1'b0, 2'd2, 32'h0, 4'hF); settle();
        chk("mr_wait0", m0_waitrequest, 0);
        next();
        reset = 1'b1;
        drv0(1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
        drv1(1'b1, 1'b0, 2'd3, 32'h0, 4'hF);
        settle();
        chk("mr_rdv0", m0_readdatavalid, 0);
        chk("mr_rdv1", m1_readdatavalid, 0);
        chk("mr_wait0_rst", m0_waitrequest, 1);
        chk("mr_wait1_rst", m1_waitrequest, 1);
        chk("mr_cs", mem_chipselect, 0);
        chk("mr_rstreq", mem_reset_req, 1);
        next(); settle();
        chk("mr2_rdv0", m0_readdatavalid, 0);
        chk("mr2_mwr", mem_write, 0);
        next(); reset = 1'b0; settle();
        chk("mr_post_wait0", m0_waitrequest, 0);
        chk("mr_post_wait1", m1_waitrequest, 1);
        chk("mr_post_rdv0", m0_readdatavalid, 0);
        next(); settle();
        chk("mr_post2_wait1", m1_waitrequest, 0);
        chk("mr_post2_rdv0", m0_readdatavalid, 1);
        chk("mr_post2_data0", m0_readdata, 32'h01010101);
        next();
        drv0(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        drv1(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        settle();
        chk("mr_post3_rdv1", m1_readdatavalid, 1);
        chk("mr_post3_data1", m1_readdata, 32'h03030303);
        next(); settle();
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM slave (word-addressed, 1-cycle read latency, byte enables) between two Avalon-MM masters, m0 and m1, using round-robin arbitration.
- Issues at most one command per cycle to the RAM.
- Returns read data to the issuing master with readdatavalid, one cycle after issue.
- Sits between the interconnect and the RAM instance in the SoC.

Parameters:
- ADDR_W, 2, word address width of the RAM
- DATA_W, 32, data width; must be a multiple of 8
- BE_W, DATA_W/8, byteenable width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  m0_readdata valid this cycle
- m0_waitrequest  out  1  master 0 command not accepted this cycle
- m1_* (address, byteenable, read, write, writedata, readdata, readdatavalid, waitrequest): identical set for master 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_reset_req  out  1  RAM reset request
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after a read issue
- busy  out  1  read return pending or any request present

Behaviour:
- Request: req_i = mi_read | mi_write. If both read and write are asserted, the command is treated as a write and no readdatavalid is produced.
- Priority pointer last_grant, 1 bit register, reset value 1, so m0 has first priority after reset.
- Combinational grant:
  - Only one master requesting: that master is granted.
  - Both requesting: the master != last_grant is granted.
  - Neither requesting: no issue.
- Issue cycle, combinational:
  - mem_chipselect = 1; mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_write = granted master's write.
  - mi_waitrequest = req_i & ~grant_i.
  - With no grant, mem_chipselect = 0, mem_write = 0, and mem_address/byteenable/writedata are muxed from m0.
- On an issue edge: last_grant <= granted index.
- Read return registers:
  - rd_pending <= issue & ~write; rd_owner <= granted index.
  - Next cycle: m{rd_owner}_readdatavalid = rd_pending. Both mi_readdata = mem_readdata unconditionally; consumers qualify with readdatavalid.
- Back-to-back issues are allowed every cycle. Read throughput is one read per cycle, returned in issue order.
- Write has zero return latency: waitrequest low for one cycle completes it.
- Masters hold their command stable while waitrequest is high (Avalon rule). The arbiter does not latch requests.
- Starvation bound: with both masters requesting continuously, each is granted every second cycle, so maximum waitrequest run is 1 cycle.
- mem_clken = 1 constant. mem_reset_req = reset, combinational pass-through.
- Reset (sync): last_grant = 1, rd_pending = 0, rd_owner = 0.
  - During reset, waitrequest = 1 for both masters, mem_chipselect = 0, mem_write = 0, readdatavalid = 0.
  - A read issued the cycle before reset is asserted produces no readdatavalid; it is dropped.
- busy = rd_pending | req_0 | req_1.

Test Plan:
- Single read: reset, m0 writes 0xDEADBEEF to addr 2 with byteenable 0xF. m0 then reads addr 2 → waitrequest 0 in the issue cycle; next cycle m0_readdatavalid = 1 with m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention: both masters read continuously from cycle 0 (m0 addr 1, m1 addr 3) → grants alternate m0, m1, m0, ...; each waitrequest high at most 1 consecutive cycle; readdatavalid alternates owners one cycle behind grants with correct data.
- Byte enables: mem preloaded 0x11223344 at addr 0; m1 writes 0xAABBCCDD with byteenable 0x5 → a subsequent read returns 0x11BB33DD.
- Simultaneous write and read: m0 writes addr 0 while m1 reads addr 0 in the same cycle, with last_grant = 1 → m0's write issues first; m1's read issues next cycle and returns the new data.
- Read + write both asserted on m1 → treated as a write; m1_readdatavalid never asserts.
- Reset mid-operation: m0 read issued, reset asserted the following cycle → no readdatavalid. During reset, both waitrequests = 1, mem_chipselect = 0, mem_reset_req = 1. After release, m0 is granted first under contention.
